tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised successor to the fixed single-tone beeper: plays a programmable sequence of up to DEPTH notes from an internal note table.
- Each note has its own half-period, or is a rest, and its own duration.
- Started by a key press; supports one-shot or looping playback and a synchronous abort.
- Sits between the front-panel key/LED logic and the piezo driver pin.

Parameters:
- PERIOD_W, 16: width of the half-period field, in clk cycles.
- DUR_W, 16: width of the duration field, in ticks.
- DEPTH, 8: number of note table entries (power of 2, at least 2).
- TICK_DIV, 1000: clk cycles per duration tick (at least 1).
- GAP_TICKS, 1: silent gap between notes, in ticks; used only with the optional feature.
- IDX_W, $clog2(DEPTH): derived localparam, not overridable.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key1  in  1  start request; a rising edge (registered edge detect) starts playback
- stop  in  1  synchronous abort, level sampled
- loop_mode  in  1  1 = restart at entry 0 after the last note; sampled at each end of sequence
- wr_en  in  1  note table write strobe
- wr_addr  in  IDX_W  write index
- wr_half_period  in  PERIOD_W  beep toggle interval; 0 = rest
- wr_duration  in  DUR_W  note length in ticks; 0 is treated as 1
- wr_last  in  1  end-of-sequence marker for this entry
- beep  out  1  square-wave output
- ready  out  1  high while a sequence is playing (busy)
- done  out  1  one-cycle pulse when a one-shot sequence completes normally
- note_idx  out  IDX_W  index of the current note
- led0  out  1  toggles on every note advance
- led1  out  1  copy of ready

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; note_idx 0; edge-detect register 0. Table contents are not cleared by reset, so the bench must write entries before use.
- States:
  - IDLE: ready 0, beep 0.
  - LOAD: one cycle; reads table[note_idx]; clears tone and tick counters; drives beep 0.
  - PLAY: generates the tone for the current note.
  - GAP: only with the optional feature.
- Start:
  - key1 rising edge sampled in IDLE at cycle N: LOAD at N+1 with ready=1, note_idx=0; PLAY from N+2.
  - key1 edges outside IDLE are ignored; there is no restart.
- Tone generation in PLAY:
  - The tone counter counts 0..half_period-1; beep toggles when the count equals half_period-1, then the counter wraps to 0.
  - half_period=1 gives a toggle every cycle. half_period=0 holds beep at 0.
- Duration:
  - The tick counter counts 0..TICK_DIV-1; the remaining-duration counter decrements on each wrap.
  - A note occupies exactly max(duration,1)*TICK_DIV PLAY cycles.
- Note advance (remaining reaches 0):
  - If the entry's last flag is 0 and note_idx != DEPTH-1: note_idx+1, go to LOAD, toggle led0.
  - Otherwise, end of sequence:
    - loop_mode=1: note_idx=0, go to LOAD, toggle led0.
    - loop_mode=0: go to IDLE, beep 0, ready 0, done=1 for one cycle, note_idx=0.
  - Entry DEPTH-1 is always treated as last.
- Stop:
  - stop=1 in any non-IDLE state: IDLE on the next cycle, beep 0, ready 0, note_idx 0, no done pulse.
  - stop has priority over advance and loop. stop=1 in IDLE blocks a start in the same cycle.
- Writes:
  - Accepted only in IDLE; wr_en while ready=1 is dropped.
  - wr_en together with a start edge in IDLE: the write commits, and LOAD reads the new value if wr_addr=0.
- Reset mid-playback: next cycle all outputs at reset values; table retained.
- Counters are unsigned; none can overflow given the wrap rules.

Optional Feature:
- Macro: TONE_SEQ_GAP_EN.
- Defined: after each note except the sequence end, the FSM enters GAP for GAP_TICKS*TICK_DIV cycles with beep 0 and ready 1. led0 toggles on entering GAP, then GAP goes to LOAD. stop aborts GAP like PLAY.
- Undefined: no GAP state; notes run back to back with only the 1-cycle LOAD between them.

Test Plan:
1. TICK_DIV=4; entry0 = {hp=3, dur=2, last=1}; key1 pulse -> ready rises 1 cycle after the edge; beep toggles every 3 cycles; 8 PLAY cycles; done pulses once; ready falls.
2. Three entries {hp=2,dur=1}, {hp=0,dur=2}, {hp=1,dur=1,last=1} -> beep toggles every 2 cycles, then held 0 for 8 cycles, then toggles every cycle; note_idx steps 0,1,2; led0 toggles twice.
3. loop_mode=1 with a 2-note table -> note_idx wraps 1->0, no done pulse. Assert stop mid-note -> ready and beep 0 on the next cycle, no done.
4. wr_en to entry 0 while ready=1 -> table unchanged on replay. Simultaneous write and start in IDLE -> new entry played.
5. key1 held high or re-pulsed during PLAY -> no restart. reset asserted mid-note -> all outputs 0 next cycle; a new key1 replays from entry 0 with the table intact.
6. With TONE_SEQ_GAP_EN and GAP_TICKS=1, TICK_DIV=4 -> 4 cycles of silence with ready=1 between notes; no gap after the last note.

Source files
------------

// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a programmable note table as a square wave on beep.
// Define TONE_SEQ_GAP_EN to insert a silent GAP of GAP_TICKS ticks between notes.
module tone_sequencer #(
  parameter int PERIOD_W = 16,
  parameter int DUR_W = 16,
  parameter int DEPTH = 8,
  parameter int TICK_DIV = 1000,
  parameter int GAP_TICKS = 1
) (
  input logic clk,
  input logic reset,
  input logic key1,
  input logic stop,
  input logic loop_mode,
  input logic wr_en,
  input logic [$clog2(DEPTH)-1:0] wr_addr,
  input logic [PERIOD_W-1:0] wr_half_period,
  input logic [DUR_W-1:0] wr_duration,
  input logic wr_last,
  output logic beep,
  output logic ready,
  output logic done,
  output logic [$clog2(DEPTH)-1:0] note_idx,
  output logic led0,
  output logic led1
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TICK_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
`ifdef TONE_SEQ_GAP_EN
    PLAY,
    GAP
`else
    PLAY
`endif
  } state_t;
`ifdef TONE_SEQ_GAP_EN
  localparam state_t ADV = GAP;
`else
  localparam state_t ADV = LOAD;
`endif
  logic [PERIOD_W-1:0] tbl_hp [DEPTH];
  logic [DUR_W-1:0] tbl_dur [DEPTH];
  logic tbl_last [DEPTH];
  state_t state, state_n;
  logic key_q, start, tick_wrap, note_end, seq_end, adv, tone_wrap;
  logic beep_r, last_r, led0_r, done_r;
  logic [PERIOD_W-1:0] hp, tone_cnt;
  logic [DUR_W-1:0] rem;
  logic [TICK_W-1:0] tick_cnt;
  logic [IDX_W-1:0] idx;
  assign start = state == IDLE && key1 && !key_q && !stop;
  assign tick_wrap = tick_cnt == TICK_W'(TICK_DIV - 1);
  assign note_end = tick_wrap && rem == DUR_W'(1);
  assign seq_end = last_r || idx == IDX_W'(DEPTH - 1);
  assign adv = state == PLAY && note_end;
  assign tone_wrap = tone_cnt == hp - 1'b1;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? LOAD : IDLE;
      LOAD: state_n = PLAY;
      PLAY: if (note_end) state_n = !seq_end ? ADV : loop_mode ? LOAD : IDLE;
`ifdef TONE_SEQ_GAP_EN
      GAP: if (note_end) state_n = LOAD;
`endif
      default: state_n = IDLE;
    endcase
    if (stop && state != IDLE) state_n = IDLE;
  end
  // the table survives reset; writes are only honoured while idle
  always_ff @(posedge clk) begin
    if (wr_en && state == IDLE) begin
      tbl_hp[wr_addr] <= wr_half_period;
      tbl_dur[wr_addr] <= wr_duration;
      tbl_last[wr_addr] <= wr_last;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      key_q <= 1'b0;
      idx <= '0;
      led0_r <= 1'b0;
      done_r <= 1'b0;
      beep_r <= 1'b0;
      last_r <= 1'b0;
      hp <= '0;
      tone_cnt <= '0;
      tick_cnt <= '0;
      rem <= '0;
    end else begin
      state <= state_n;
      key_q <= key1;
      done_r <= 1'b0;
      if (state == LOAD) begin
        hp <= tbl_hp[idx];
        last_r <= tbl_last[idx];
        rem <= tbl_dur[idx] == '0 ? DUR_W'(1) : tbl_dur[idx];
        tone_cnt <= '0;
        tick_cnt <= '0;
        beep_r <= 1'b0;
      end else if (state != IDLE) begin
        tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
        rem <= tick_wrap ? rem - 1'b1 : rem;
      end
      if (state == PLAY && hp != '0) begin
        tone_cnt <= tone_wrap ? '0 : tone_cnt + 1'b1;
        beep_r <= beep_r ^ tone_wrap;
      end
      // advancing into a gap reuses the tick/remaining counters for its length
      if (adv && !stop) begin
        led0_r <= led0_r ^ (!seq_end || loop_mode);
        done_r <= seq_end && !loop_mode;
        rem <= DUR_W'(GAP_TICKS);
      end
      idx <= (state_n == IDLE || (adv && seq_end)) ? '0 : adv ? idx + 1'b1 : idx;
    end
  end
  assign beep = beep_r && state == PLAY;
  assign ready = state != IDLE;
  assign done = done_r;
  assign note_idx = idx;
  assign led0 = led0_r;
  assign led1 = ready;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scenario tasks compared against a per-cycle trace model of the note table.
module tb_tone_sequencer;
  localparam int TD = 4;
  localparam int DP = 8;
  localparam int GT = 1;
  localparam int IW = $clog2(DP);
  logic clk = 0, reset = 1, key1 = 0, stop = 0, loop_mode = 0, wr_en = 0, wr_last = 0;
  logic [IW-1:0] wr_addr = '0;
  logic [15:0] wr_half_period = '0, wr_duration = '0;
  logic beep, ready, done, led0, led1;
  logic [IW-1:0] note_idx;
  int runs = 0, fails = 0;
  int m_hp [DP];
  int m_dur [DP];
  bit m_last [DP];
  bit mdl_led = 0;
  logic [7:0] exp_q [$];
  logic [7:0] o;
  tone_sequencer #(.PERIOD_W(16), .DUR_W(16), .DEPTH(DP), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .key1(key1), .stop(stop), .loop_mode(loop_mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_half_period(wr_half_period),
    .wr_duration(wr_duration), .wr_last(wr_last), .beep(beep), .ready(ready),
    .done(done), .note_idx(note_idx), .led0(led0), .led1(led1)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] obs();
    return {done, ready, beep, led0, led1, note_idx};
  endfunction
  function automatic logic [7:0] ev(bit d, bit r, bit b, bit l, int i);
    logic [IW-1:0] x;
    x = IW'(i);
    return {d, r, b, l, r, x};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int a, input int h, input int d, input bit l);
    wr_en = 1; wr_addr = IW'(a); wr_half_period = 16'(h); wr_duration = 16'(d); wr_last = l;
    step();
    wr_en = 0;
    m_hp[a] = h; m_dur[a] = d; m_last[a] = l;
  endtask
  task automatic kick();
    key1 = 0;
    step();
    key1 = 1;
    step();
    key1 = 0;
  endtask
  // expected per-cycle trace from the start edge, built note by note from the table
  task automatic gen(input bit lp, input int maxn);
    int i, p;
    bit led, fin;
    exp_q.delete();
    i = 0; led = mdl_led; fin = 0;
    while (!fin && exp_q.size() < maxn) begin
      exp_q.push_back(ev(0, 1, 0, led, i));
      p = (m_dur[i] == 0 ? 1 : m_dur[i]) * TD;
      for (int j = 0; j < p; j++)
        exp_q.push_back(ev(0, 1, m_hp[i] == 0 ? 1'b0 : ((j / m_hp[i]) % 2) == 1, led, i));
      if (!m_last[i] && i != DP - 1) begin
        led = !led;
        i++;
`ifdef TONE_SEQ_GAP_EN
        for (int g = 0; g < GT * TD; g++) exp_q.push_back(ev(0, 1, 0, led, i));
`endif
      end else if (lp) begin
        led = !led;
        i = 0;
      end else begin
        exp_q.push_back(ev(1, 0, 0, led, 0));
        exp_q.push_back(ev(0, 0, 0, led, 0));
        fin = 1;
      end
    end
  endtask
  task automatic test_reset();
    reset = 1;
    repeat (3) step();
    runs++;
    if (obs() !== 8'h00) begin fails++; $display("FAIL reset got %b want %b", obs(), 8'h00); end
    reset = 0;
    step();
    runs++;
    if (obs() !== 8'h00) begin fails++; $display("FAIL reset_release got %b want %b", obs(), 8'h00); end
  endtask
  task automatic test_single();
    wr(0, 3, 2, 1);
    kick();
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL single k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    mdl_led = exp_q[exp_q.size() - 1][4];
  endtask
  task automatic test_three();
    wr(0, 2, 1, 0);
    wr(1, 0, 2, 0);
    wr(2, 1, 1, 1);
    kick();
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL three k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    mdl_led = exp_q[exp_q.size() - 1][4];
  endtask
  task automatic test_loop_stop();
    logic [7:0] want;
    wr(0, 3, 1, 0);
    wr(1, 2, 1, 1);
    loop_mode = 1;
    kick();
    gen(1, 30);
    for (int k = 0; k < 30; k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL loop k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    mdl_led = exp_q[29][4];
    want = ev(0, 0, 0, mdl_led, 0);
    stop = 1;
    step();
    stop = 0;
    runs++;
    if (obs() !== want) begin fails++; $display("FAIL stop got %b want %b", obs(), want); end
    loop_mode = 0;
    step();
    step();
    runs++;
    if (obs() !== want) begin fails++; $display("FAIL stop_no_done got %b want %b", obs(), want); end
    stop = 1; key1 = 1;
    step();
    key1 = 0; stop = 0;
    step();
    runs++;
    if (obs() !== want) begin fails++; $display("FAIL stop_blocks_start got %b want %b", obs(), want); end
  endtask
  task automatic test_write_busy();
    wr(0, 2, 1, 1);
    kick();
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL wr_busy k=%0d got %b want %b", k, obs(), exp_q[k]); end
      wr_en = k == 2; wr_addr = '0; wr_half_period = 16'd5; wr_duration = 16'd3; wr_last = 0;
    end
    wr_en = 0;
    mdl_led = exp_q[exp_q.size() - 1][4];
    kick();
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL wr_replay k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    mdl_led = exp_q[exp_q.size() - 1][4];
    step();
    wr_en = 1; wr_addr = '0; wr_half_period = 16'd1; wr_duration = 16'd2; wr_last = 1; key1 = 1;
    step();
    wr_en = 0; key1 = 0;
    m_hp[0] = 1; m_dur[0] = 2; m_last[0] = 1;
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL wr_start k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    mdl_led = exp_q[exp_q.size() - 1][4];
  endtask
  task automatic test_no_restart();
    wr(0, 2, 1, 0);
    wr(1, 0, 2, 0);
    wr(2, 1, 1, 1);
    step();
    key1 = 1;
    step();
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL key_held k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    mdl_led = exp_q[exp_q.size() - 1][4];
    key1 = 0;
    kick();
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL key_repulse k=%0d got %b want %b", k, obs(), exp_q[k]); end
      key1 = k == 5 || k == 8;
    end
    key1 = 0;
    mdl_led = exp_q[exp_q.size() - 1][4];
  endtask
  task automatic test_reset_mid();
    kick();
    gen(0, 1000);
    for (int k = 0; k < 7; k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL pre_reset k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    reset = 1;
    step();
    runs++;
    if (obs() !== 8'h00) begin fails++; $display("FAIL reset_mid got %b want %b", obs(), 8'h00); end
    reset = 0;
    mdl_led = 0;
    kick();
    gen(0, 1000);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k != 0) step();
      runs++;
      if (obs() !== exp_q[k]) begin fails++; $display("FAIL post_reset k=%0d got %b want %b", k, obs(), exp_q[k]); end
    end
    mdl_led = exp_q[exp_q.size() - 1][4];
  endtask
  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < DP; a++)
        wr(a, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      kick();
      gen(0, 1000);
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k != 0) step();
        runs++;
        o = obs();
        if (o !== exp_q[k]) begin fails++; $display("FAIL random r=%0d k=%0d got %b want %b", r, k, o, exp_q[k]); end
      end
      mdl_led = exp_q[exp_q.size() - 1][4];
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_three();
    test_loop_stop();
    test_write_busy();
    test_no_restart();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
